// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, fetch defaults, fetch-state encodings
// and the opcodes that decode and the ALU agree on.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W  = 16;
  localparam int unsigned CPU_INSTR_W = 8;

  localparam logic [15:0] CPU_RESET_PC   = 16'h0000;
  localparam logic [7:0]  CPU_HALT_INSTR = 8'hFF;

  // Fetch sequencer states, kept as plain constants for legacy tooling
  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  // Opcodes shared with decode/ALU
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_INC = 3'b011;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bundle: hazard/redirect inputs, instruction ROM port and the
// IF/ID payload handed to decode.
interface pc_fetch_ctrl_if import cpu_pkg::*; #(
  parameter int unsigned ADDR_W  = CPU_ADDR_W,
  parameter int unsigned INSTR_W = CPU_INSTR_W
);

  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_id_valid;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc;
  logic               halted;
  logic [31:0]        fetch_count;

  // Fetch controller side
  modport master (
    input  stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, if_id_valid, if_id_instr, if_id_pc, halted, fetch_count
  );

  // Surrounding pipeline / ROM side
  modport slave (
    output stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, if_id_valid, if_id_instr, if_id_pc, halted, fetch_count
  );

endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer feeding decode from a 1-cycle-latency
// synchronous instruction ROM. Handles stall, redirect with squash, HALT and
// an accepted-instruction counter.
module pc_fetch_ctrl import cpu_pkg::*; #(
  parameter int unsigned        ADDR_W     = CPU_ADDR_W,
  parameter int unsigned        INSTR_W    = CPU_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC   = ADDR_W'(CPU_RESET_PC),
  parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(CPU_HALT_INSTR)
) (
  input logic             clk,
  input logic             resetn,
  pc_fetch_ctrl_if.master bus
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] fetch_addr;
  logic              valid_q, valid_d;
  logic [31:0]       count_q;
  logic              squash;
  logic              payload_valid;
  logic              accept;
  logic              halt_on_out;

  assign squash        = bus.redirect_valid;
  assign payload_valid = valid_q & ~squash;
  assign accept        = payload_valid & ~bus.stall;
  // HALT word currently presented to decode while running
  assign halt_on_out   = (state_q == S_RUN) && (bus.imem_rdata == HALT_INSTR);

  assign bus.if_id_valid = payload_valid;
  assign bus.if_id_instr = bus.imem_rdata;
  assign bus.if_id_pc    = pc_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.fetch_count = count_q;
  assign bus.imem_addr   = fetch_addr;

  // Address for the ROM: redirect first, then boot, then hold or advance
  always_comb begin
    fetch_addr = pc_q + ADDR_W'(1);
    if (bus.redirect_valid) begin
      fetch_addr = bus.redirect_pc;
    end else if (state_q == S_BOOT) begin
      fetch_addr = RESET_PC;
    end else if (state_q == S_HALT) begin
      fetch_addr = pc_q;
    end else if (bus.stall || halt_on_out) begin
      // Re-read the same word so the ROM output holds; never prefetch past HALT
      fetch_addr = pc_q;
    end
  end

  // Fetch state and payload-valid next state
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        valid_d = 1'b1;
      end
      S_RUN: begin
        if (bus.redirect_valid) begin
          valid_d = 1'b1;
        end else if (accept && (bus.imem_rdata == HALT_INSTR)) begin
          state_d = S_HALT;
          valid_d = 1'b0;
        end
      end
      S_HALT: begin
        if (bus.redirect_valid) begin
          state_d = S_RUN;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  // PC tracks the address whose data arrives next cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= fetch_addr;
    end
  end

  // State and valid registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_BOOT;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Count words decode actually took; squashed words never reach accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= 32'd0;
    end else if (accept) begin
      count_q <= count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: two instances (reset PC 0x0000 and 0xFFFE)
// each with a behavioural 1-cycle ROM; accepted payloads are checked against a
// queue of expected (pc, instr) pairs.
module tb_pc_fetch_ctrl;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  instr;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        stall;
  logic        rv;
  logic [15:0] rp;
  logic        halt_en;
  logic        sel;
  logic [7:0]  rdata_a, rdata_b;

  int unsigned errors;
  int unsigned checks;
  exp_t        sb[$];

  pc_fetch_ctrl_if #(.ADDR_W(16), .INSTR_W(8)) bus_a ();
  pc_fetch_ctrl_if #(.ADDR_W(16), .INSTR_W(8)) bus_b ();

  pc_fetch_ctrl #(
    .ADDR_W(16), .INSTR_W(8), .RESET_PC(16'h0000), .HALT_INSTR(8'hFF)
  ) u_dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a)
  );

  pc_fetch_ctrl #(
    .ADDR_W(16), .INSTR_W(8), .RESET_PC(16'hFFFE), .HALT_INSTR(8'hFF)
  ) u_dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b)
  );

  assign bus_a.stall          = stall;
  assign bus_a.redirect_valid = rv;
  assign bus_a.redirect_pc    = rp;
  assign bus_a.imem_rdata     = rdata_a;
  assign bus_b.stall          = stall;
  assign bus_b.redirect_valid = rv;
  assign bus_b.redirect_pc    = rp;
  assign bus_b.imem_rdata     = rdata_b;

  // ROM contents: low 7 address bits plus one (never 0xFF), HALT at 3 on demand
  function automatic logic [7:0] rom_fn(input logic [15:0] addr);
    if (halt_en && addr == 16'd3) return 8'hFF;
    return {1'b0, addr[6:0]} + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    rdata_a <= rom_fn(bus_a.imem_addr);
    rdata_b <= rom_fn(bus_b.imem_addr);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed outputs of the instance under test
  logic        o_valid, o_halted;
  logic [15:0] o_addr, o_pc;
  logic [7:0]  o_instr;
  logic [31:0] o_cnt;
  always_comb begin
    o_valid  = sel ? bus_b.if_id_valid : bus_a.if_id_valid;
    o_halted = sel ? bus_b.halted      : bus_a.halted;
    o_addr   = sel ? bus_b.imem_addr   : bus_a.imem_addr;
    o_pc     = sel ? bus_b.if_id_pc    : bus_a.if_id_pc;
    o_instr  = sel ? bus_b.if_id_instr : bus_a.if_id_instr;
    o_cnt    = sel ? bus_b.fetch_count : bus_a.fetch_count;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_word(input logic [15:0] pc);
    sb.push_back('{pc: pc, instr: rom_fn(pc)});
  endtask

  // One cycle: drive inputs after negedge, then score any accepted payload
  task automatic cyc(input logic st, input logic r, input logic [15:0] p);
    exp_t e;
    @(negedge clk);
    stall = st;
    rv    = r;
    rp    = p;
    #1;
    if (o_valid && !st) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow: observed accept at pc %0h expected none", o_pc);
      end else begin
        e = sb.pop_front();
        chk("acc_pc", o_pc, e.pc);
        chk("acc_instr", o_instr, e.instr);
      end
    end
  endtask

  task automatic assert_reset(input logic [15:0] rst_pc);
    resetn = 1'b0;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_halted", o_halted, 0);
    chk("rst_addr", o_addr, rst_pc);
    chk("rst_pc", o_pc, rst_pc);
    chk("rst_cnt", o_cnt, 0);
  endtask

  task automatic release_reset(input logic [15:0] rst_pc);
    @(negedge clk);
    stall  = 1'b0;
    rv     = 1'b0;
    resetn = 1'b1;
    #1;
    chk("boot_valid", o_valid, 0);
    chk("boot_addr", o_addr, rst_pc);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    stall   = 1'b0;
    rv      = 1'b0;
    rp      = 16'h0;
    halt_en = 1'b0;
    sel     = 1'b0;
    resetn  = 1'b0;

    // Free run, stall, redirect on instance A
    #3;
    assert_reset(16'h0000);
    @(negedge clk);
    release_reset(16'h0000);
    for (int i = 0; i < 7; i++) exp_word(16'(i));
    exp_word(16'h0040);
    exp_word(16'h0041);
    cyc(0, 0, 0);
    chk("run0_valid", o_valid, 1);
    chk("run0_addr", o_addr, 16'h0001);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("cnt_after3", o_cnt, 3);
    cyc(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0);
      chk("stall_addr", o_addr, 16'h0005);
      chk("stall_pc", o_pc, 16'h0005);
      chk("stall_instr", o_instr, 8'h06);
      chk("stall_cnt", o_cnt, 5);
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("post_stall_pc", o_pc, 16'h0006);
    cyc(0, 1, 16'h0040);
    chk("redir_valid", o_valid, 0);
    chk("redir_addr", o_addr, 16'h0040);
    chk("redir_pc_squashed", o_pc, 16'h0007);
    cyc(0, 0, 0);
    chk("target_valid", o_valid, 1);
    chk("target_pc", o_pc, 16'h0040);
    chk("squash_cnt", o_cnt, 7);
    cyc(0, 0, 0);
    chk("cnt_after_target", o_cnt, 8);

    // HALT at address 3, resume by redirect, then reset mid-run
    halt_en = 1'b1;
    @(negedge clk);
    assert_reset(16'h0000);
    release_reset(16'h0000);
    for (int i = 0; i < 4; i++) exp_word(16'(i));
    exp_word(16'h0010);
    exp_word(16'h0011);
    exp_word(16'h0020);
    exp_word(16'h0021);
    exp_word(16'h0000);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("halt_word_pc", o_pc, 16'h0003);
    chk("halt_word_instr", o_instr, 8'hFF);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0);
      chk("halted", o_halted, 1);
      chk("halt_valid", o_valid, 0);
      chk("halt_addr", o_addr, 16'h0003);
      chk("halt_cnt", o_cnt, 4);
    end
    cyc(0, 1, 16'h0010);
    chk("resume_addr", o_addr, 16'h0010);
    cyc(0, 0, 0);
    chk("resume_valid", o_valid, 1);
    chk("resume_pc", o_pc, 16'h0010);
    chk("resume_halted", o_halted, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 16'h0020);
    chk("redir2_valid", o_valid, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    @(negedge clk);
    stall = 1'b0;
    rv    = 1'b0;
    #1;
    chk("pre_reset_pc", o_pc, 16'h0022);
    chk("pre_reset_cnt", o_cnt, 8);
    assert_reset(16'h0000);
    release_reset(16'h0000);
    cyc(0, 0, 0);
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_pc", o_pc, 16'h0000);
    chk("post_rst_cnt", o_cnt, 0);

    // Instance B: reset PC 0xFFFE wraps; redirect beats stall
    halt_en = 1'b0;
    sel     = 1'b1;
    @(negedge clk);
    assert_reset(16'hFFFE);
    release_reset(16'hFFFE);
    exp_word(16'hFFFE);
    exp_word(16'hFFFF);
    exp_word(16'h0000);
    exp_word(16'h0001);
    exp_word(16'h0080);
    cyc(0, 0, 0);
    chk("wrap_pc0", o_pc, 16'hFFFE);
    chk("wrap_addr0", o_addr, 16'hFFFF);
    cyc(0, 0, 0);
    chk("wrap_pc1", o_pc, 16'hFFFF);
    chk("wrap_addr1", o_addr, 16'h0000);
    cyc(0, 0, 0);
    chk("wrap_pc2", o_pc, 16'h0000);
    cyc(0, 0, 0);
    chk("wrap_pc3", o_pc, 16'h0001);
    cyc(1, 1, 16'h0080);
    chk("rs_valid", o_valid, 0);
    chk("rs_addr", o_addr, 16'h0080);
    cyc(0, 0, 0);
    chk("rs_target_valid", o_valid, 1);
    chk("rs_target_pc", o_pc, 16'h0080);
    chk("rs_cnt", o_cnt, 4);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
